// File: rtl/ebus_cycle_seq_pkg.sv
// ebus_cycle_seq_pkg: shared backplane types for the EBUS master cycle sequencer
//   tSeqState   - sequencer state encoding
//   FCN_*       - EBUS function codes
//   tEBUSdriver - one master's driver slot into the EBUS data mux
package ebus_cycle_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_DEMAND,
        ST_RELEASE,
        ST_RECOVER
    } tSeqState;

    localparam logic [2:0] FCN_CONO  = 3'd0;
    localparam logic [2:0] FCN_CONI  = 3'd1;
    localparam logic [2:0] FCN_DATAO = 3'd2;
    localparam logic [2:0] FCN_DATAI = 3'd3;

    // data uses KL bit numbering: bit 0 is the MSB
    typedef struct packed {
        logic        driving;
        logic [0:35] data;
    } tEBUSdriver;

endpackage

// File: rtl/ebus_cycle_seq_wait_ctr.sv
// ebus_wait_ctr: loadable 8-bit down-counter timing SETUP, DEMAND timeout and RECOVER
//   clk, crobar_l - clock, async active-low reset
//   i_load, i_val - load i_val (wins over counting)
//   o_last        - count is 1: the current cycle is the final one of the phase
module ebus_wait_ctr (
    input  logic       clk,
    input  logic       crobar_l,
    input  logic       i_load,
    input  logic [7:0] i_val,
    output logic       o_last
);
    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge crobar_l)
        if (!crobar_l)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (r_cnt != 8'd0)
            r_cnt <= r_cnt - 8'd1;

    assign o_last = r_cnt == 8'd1;
endmodule

// File: rtl/ebus_cycle_seq.sv
// ebus_cycle_seq: EBUS master cycle sequencer (IDLE -> SETUP -> DEMAND -> RELEASE -> RECOVER)
//   clk, crobar_l                    - clock, async active-low reset
//   req_valid/req_ready              - request handshake; ready only in IDLE
//   req_write/cs/fcn/wdata           - cycle to run, latched on accept
//   rsp_valid/rsp_rdata/rsp_timeout  - one-cycle completion pulse in RELEASE
//   ebus_cs/ebus_fcn/ebus_demand     - bus address/function/strobe
//   EBUSdriver                       - write-data driver slot for the bus mux
//   ebus_xfer/ebus_data              - device acknowledge and resolved bus data
module ebus_cycle_seq
    import ebus_cycle_seq_pkg::*;
#(
    parameter int SETUP_CYC   = 2,
    parameter int TIMEOUT_CYC = 255,
    parameter int RECOV_CYC   = 1
) (
    input  logic        clk,
    input  logic        crobar_l,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [6:0]  req_cs,
    input  logic [2:0]  req_fcn,
    input  logic [0:35] req_wdata,
    output logic        rsp_valid,
    output logic [0:35] rsp_rdata,
    output logic        rsp_timeout,
    output logic [6:0]  ebus_cs,
    output logic [2:0]  ebus_fcn,
    output logic        ebus_demand,
    output tEBUSdriver  EBUSdriver,
    input  logic        ebus_xfer,
    input  logic [0:35] ebus_data
);
    tSeqState    r_state;
    logic        r_ready;
    logic        r_write;
    logic        r_rsp_valid;
    logic        r_timeout;
    logic [0:35] r_rdata;
    logic [6:0]  r_cs;
    logic [2:0]  r_fcn;
    logic        r_demand;
    tEBUSdriver  r_drv;
    logic        w_load;
    logic [7:0]  w_val;
    logic        w_last;

    // the counter is reloaded on every phase entry, so o_last marks each phase's final cycle
    assign w_load = (r_state == ST_IDLE && req_valid) || (r_state == ST_SETUP && w_last) ||
                    r_state == ST_RELEASE;
    assign w_val  = r_state == ST_IDLE  ? 8'(SETUP_CYC) :
                    r_state == ST_SETUP ? 8'(TIMEOUT_CYC) : 8'(RECOV_CYC);

    ebus_wait_ctr u_wait_ctr (
        .clk      (clk),
        .crobar_l (crobar_l),
        .i_load   (w_load),
        .i_val    (w_val),
        .o_last   (w_last)
    );

    always_ff @(posedge clk or negedge crobar_l)
        if (!crobar_l) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b1;
            r_write     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_rdata     <= '0;
            r_cs        <= '0;
            r_fcn       <= '0;
            r_demand    <= 1'b0;
            r_drv       <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE:
                    if (req_valid) begin
                        r_state      <= ST_SETUP;
                        r_ready      <= 1'b0;
                        r_write      <= req_write;
                        r_cs         <= req_cs;
                        r_fcn        <= req_fcn;
                        r_drv.driving <= req_write;
                        r_drv.data   <= req_write ? req_wdata : '0;
                    end
                ST_SETUP:
                    if (w_last) begin
                        r_state  <= ST_DEMAND;
                        r_demand <= 1'b1;
                    end
                ST_DEMAND:
                    // XFER in the final timeout cycle still completes normally
                    if (ebus_xfer || w_last) begin
                        r_state     <= ST_RELEASE;
                        r_demand    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_timeout   <= !ebus_xfer;
                        r_rdata     <= (ebus_xfer && !r_write) ? ebus_data : '0;
                    end
                ST_RELEASE: begin
                    r_state   <= (RECOV_CYC == 0) ? ST_IDLE : ST_RECOVER;
                    r_ready   <= RECOV_CYC == 0;
                    r_timeout <= 1'b0;
                    r_cs      <= '0;
                    r_fcn     <= '0;
                    r_drv     <= '0;
                end
                ST_RECOVER:
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end

    assign req_ready   = r_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign rsp_timeout = r_timeout;
    assign ebus_cs     = r_cs;
    assign ebus_fcn    = r_fcn;
    assign ebus_demand = r_demand;
    assign EBUSdriver  = r_drv;
endmodule

// File: tb/tb_ebus_cycle_seq.sv
// tb_ebus_cycle_seq: directed self-checking bench for ebus_cycle_seq (SETUP=2, TIMEOUT=4, RECOV=1)
module tb_ebus_cycle_seq;
    import ebus_cycle_seq_pkg::*;

    localparam int S = 2;
    localparam int T = 4;
    localparam int R = 1;

    logic        clk = 1'b0;
    logic        crobar_l = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [6:0]  req_cs = '0;
    logic [2:0]  req_fcn = '0;
    logic [0:35] req_wdata = '0;
    logic        rsp_valid;
    logic [0:35] rsp_rdata;
    logic        rsp_timeout;
    logic [6:0]  ebus_cs;
    logic [2:0]  ebus_fcn;
    logic        ebus_demand;
    tEBUSdriver  EBUSdriver;
    logic        ebus_xfer = 1'b0;
    logic [0:35] ebus_data = '0;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    ebus_cycle_seq #(.SETUP_CYC(S), .TIMEOUT_CYC(T), .RECOV_CYC(R)) dut (
        .clk         (clk),
        .crobar_l    (crobar_l),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_cs      (req_cs),
        .req_fcn     (req_fcn),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .ebus_cs     (ebus_cs),
        .ebus_fcn    (ebus_fcn),
        .ebus_demand (ebus_demand),
        .EBUSdriver  (EBUSdriver),
        .ebus_xfer   (ebus_xfer),
        .ebus_data   (ebus_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, ".idle_cs"}, ebus_cs, 0);
        check({tag, ".idle_fcn"}, ebus_fcn, 0);
        check({tag, ".idle_drv"}, {EBUSdriver.driving, EBUSdriver.data}, 0);
        check({tag, ".idle_dem"}, ebus_demand, 0);
    endtask

    // Runs one bus cycle; xat = DEMAND cycle index (0 = first) in which XFER is raised, -1 = never.
    // Latency is counted inclusively from the accept cycle to the rsp_valid cycle.
    task automatic do_cycle(input string tag, input logic wr, input logic [6:0] cs, input logic [2:0] fcn,
                            input logic [35:0] wd, input int xat, input logic [35:0] xd, input logic stray,
                            input int exp_dem, input int exp_lat, input logic exp_to,
                            input logic [35:0] exp_rd, output int acc, output int rel);
        int d0, ndem, ndrv, nbad, nbus, k;
        req_write = wr;
        req_cs    = cs;
        req_fcn   = fcn;
        req_wdata = wd;
        ebus_data = xd;
        req_valid = 1'b1;
        ebus_xfer = stray;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, ".ready"}, req_ready, 1);
        acc = cyc;
        rel = -1;
        d0 = -1;
        ndem = 0;
        ndrv = 0;
        nbad = 0;
        nbus = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            ebus_xfer = 1'b0;
            if (ebus_demand) begin
                if (d0 < 0) d0 = cyc;
                ndem++;
                if (ebus_cs != cs || ebus_fcn != fcn) nbus++;
                if (cyc - d0 == xat) ebus_xfer = 1'b1;
            end
            if (EBUSdriver.driving) begin
                ndrv++;
                if (EBUSdriver.data !== wd) nbad++;
            end else if (EBUSdriver.data !== '0) nbad++;
            if (rsp_valid) begin
                rel = cyc;
                break;
            end
        end
        check({tag, ".rsp_seen"}, rel >= 0, 1);
        check({tag, ".demand_cycles"}, ndem, exp_dem);
        check({tag, ".latency"}, rel - acc + 1, exp_lat);
        check({tag, ".timeout"}, rsp_timeout, exp_to);
        check({tag, ".rdata"}, rsp_rdata, exp_rd);
        check({tag, ".drv_cycles"}, ndrv, wr ? S + exp_dem + 1 : 0);
        check({tag, ".drv_data"}, nbad, 0);
        check({tag, ".bus_cs_fcn"}, nbus, 0);
    endtask

    initial begin
        int acc, rel, acc2, rel2, k, nrsp;
        repeat (3) @(negedge clk);
        check("rst.ready", req_ready, 1);
        check("rst.demand", ebus_demand, 0);
        check("rst.cs", ebus_cs, 0);
        check("rst.fcn", ebus_fcn, 0);
        check("rst.rsp_valid", rsp_valid, 0);
        check("rst.timeout", rsp_timeout, 0);
        check("rst.rdata", rsp_rdata, 0);
        check("rst.drv", {EBUSdriver.driving, EBUSdriver.data}, 0);
        crobar_l = 1'b1;
        @(negedge clk);

        // read, XFER 3 cycles after DEMAND rises: 1 + 2 + 4 + 1 = 8 cycles
        do_cycle("rd", 1'b0, 7'o014, FCN_CONI, 36'o0, 3, 36'o123456701234, 1'b0,
                 4, 8, 1'b0, 36'o123456701234, acc, rel);
        check_idle("rd");
        @(negedge clk);
        check("rd.rdata_hold", rsp_rdata, 36'o123456701234);

        // minimum-latency read: XFER in first DEMAND cycle -> S+3
        do_cycle("rd_min", 1'b0, 7'o020, FCN_DATAI, 36'o0, 0, 36'o444333222111, 1'b0,
                 1, 5, 1'b0, 36'o444333222111, acc, rel);
        check_idle("rd_min");

        // write: data on the bus is not captured; rdata 0
        do_cycle("wr", 1'b1, 7'o014, FCN_DATAO, 36'o777000111222, 1, 36'o111111111111, 1'b0,
                 2, 6, 1'b0, 36'o0, acc, rel);
        check_idle("wr");

        // read timeout: DEMAND high T cycles
        do_cycle("rd_to", 1'b0, 7'o101, FCN_CONI, 36'o0, -1, 36'o707070707070, 1'b0,
                 4, 8, 1'b1, 36'o0, acc, rel);
        check_idle("rd_to");

        // XFER in the timeout cycle wins
        do_cycle("rd_edge", 1'b0, 7'o177, FCN_DATAI, 36'o0, 3, 36'o525252525252, 1'b0,
                 4, 8, 1'b0, 36'o525252525252, acc, rel);
        check_idle("rd_edge");

        // write timeout
        do_cycle("wr_to", 1'b1, 7'o003, FCN_CONO, 36'o000777000777, -1, 36'o222222222222, 1'b0,
                 4, 8, 1'b1, 36'o0, acc, rel);
        check_idle("wr_to");

        // back-to-back with stray XFER held through RECOVER/IDLE until accept
        do_cycle("b2b_a", 1'b0, 7'o011, FCN_CONI, 36'o0, 0, 36'o135713571357, 1'b0,
                 1, 5, 1'b0, 36'o135713571357, acc, rel);
        do_cycle("b2b_b", 1'b0, 7'o012, FCN_DATAI, 36'o0, 1, 36'o246024602460, 1'b1,
                 2, 6, 1'b0, 36'o246024602460, acc2, rel2);
        check("b2b.accept_gap", acc2 - rel, R + 1);
        check_idle("b2b");

        // reset pulsed during DEMAND of a write
        @(negedge clk);
        req_write = 1'b1;
        req_cs    = 7'o055;
        req_fcn   = FCN_DATAO;
        req_wdata = 36'o123123123123;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!ebus_demand && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("rstmid.reached_demand", ebus_demand, 1);
        #2 crobar_l = 1'b0;
        #1;
        check("rstmid.demand", ebus_demand, 0);
        check("rstmid.cs", ebus_cs, 0);
        check("rstmid.fcn", ebus_fcn, 0);
        check("rstmid.drv", {EBUSdriver.driving, EBUSdriver.data}, 0);
        check("rstmid.ready", req_ready, 1);
        check("rstmid.rsp_valid", rsp_valid, 0);
        @(negedge clk);
        crobar_l = 1'b1;
        nrsp = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || ebus_demand) nrsp++;
        end
        check("rstmid.no_rsp", nrsp, 0);
        check("rstmid.ready_after", req_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
